instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Parametrised instruction store for the CPU. Programs are loaded at run time through a
//  valid/ready write stream instead of a fixed $readmemb image.
//  Fetches go through a registered read port and are split into op/rs/rt/imm fields.
//  The block sits between the PC register and the control/register-file decode.
// PARAMETERS
//  DATA_W   16  instruction word width; must be >= 4*FIELD_W
//  DEPTH    32  number of instruction words
//  ADDR_W   16  width of IAddress
//  FIELD_W  4   width of each decoded field
//  NOP      0   DATA_W value returned for unwritten or out-of-range words
// PORTS
//  CLK         in   1        clock; all state updates on the rising edge
//  Reset       in   1        synchronous, active-high reset
//  InsMemRW    in   1        1 = request/hold load mode, 0 = run (fetch) mode
//  wr_valid    in   1        write word valid (load mode)
//  wr_data     in   DATA_W   instruction word to store
//  wr_ready    out  1        block can accept wr_data this cycle
//  loaded_cnt  out  CW       words written since load mode was entered; CW = $clog2(DEPTH+1)
//  loading     out  1        1 while the FSM is in LOAD
//  fetch_en    in   1        fetch request (run mode)
//  IAddress    in   ADDR_W   fetch word address
//  ins         out  DATA_W   registered instruction word
//  ins_valid   out  1        one-cycle pulse: ins updated by a fetch
//  addr_err    out  1        qualifies ins_valid: IAddress was >= DEPTH
//  op,rs,rt,imm out FIELD_W  ins[F-1:0], ins[2F-1:F], ins[3F-1:2F], ins[4F-1:3F] (combinational from ins)
// BEHAVIOUR
//  Reset:
//   - state=RUN; ptr/loaded_cnt=0; all per-word valid bits cleared.
//   - ins=NOP; ins_valid=0; addr_err=0; wr_ready=0; loading=0.
//   - Memory array contents are not cleared. Cleared valid bits make every word read as NOP.
//   - Reset asserted mid-load aborts the load. Words already written read as NOP afterwards.
//  FSM: two states, RUN and LOAD.
//   - RUN -> LOAD when InsMemRW=1.
//     - On entry, ptr<=0 and all valid bits are cleared in the same edge.
//   - LOAD -> RUN when InsMemRW=0. Stored words and valid bits are kept.
//  LOAD state:
//   - wr_ready = (ptr < DEPTH); the output is combinational from the state and ptr.
//   - In RUN, wr_ready=0, so the first write is accepted the cycle after the transition.
//   - A word is accepted when wr_valid & wr_ready:
//     - mem[ptr] <= wr_data;
//     - valid[ptr] <= 1;
//     - ptr <= ptr+1.
//   - wr_valid with wr_ready=0 is ignored. The source must hold the word.
//   - Full (ptr==DEPTH): wr_ready=0. The FSM stays in LOAD until InsMemRW=0. ptr does not wrap.
//   - fetch_en is ignored in LOAD: ins_valid=0 and ins holds its value.
//  RUN state fetch (latency 1):
//   - fetch_en=1 at edge n gives ins and ins_valid=1 after edge n+1.
//   - IAddress < DEPTH, valid bit set: ins = mem[IAddress]; addr_err=0.
//   - IAddress < DEPTH, valid bit clear: ins = NOP; addr_err=0.
//   - IAddress >= DEPTH: ins = NOP; addr_err=1. This covers every upper bit of the full ADDR_W.
//   - With fetch_en=0, ins_valid=0, addr_err=0 and ins holds its value.
//  Simultaneous fetch_en=1 and InsMemRW=1 in RUN:
//   - The fetch completes normally from the pre-load contents.
//   - The LOAD entry happens on the same edge.
//  loading=1 exactly while state=LOAD.
// TESTING
//  1. Reset, then fetch addr 0.
//     -> ins=NOP, ins_valid=1 one cycle later, addr_err=0; op/rs/rt/imm=0.
//  2. InsMemRW=1, stream 16'h1234 then 16'hA0F1 with wr_valid held high, then InsMemRW=0, fetch addr 1.
//     -> loaded_cnt=2; ins=16'hA0F1, op=1, rs=F, rt=0, imm=A.
//  3. Load 32 words, keep wr_valid=1.
//     -> wr_ready=0 after the 32nd word; a 33rd word is not written; loaded_cnt=32.
//     -> Fetch addr 31 returns the 32nd word.
//  4. Fetch IAddress=16'h0020 and 16'h8000.
//     -> ins=NOP, addr_err=1, ins_valid=1 for each.
//  5. Reset after 5 load writes, then fetch addr 2.
//     -> state=RUN, loaded_cnt=0, ins=NOP.
//  6. In RUN, fetch_en=1 and InsMemRW=1 in the same cycle.
//     -> The old word is returned; loading=1 next cycle; valid bits cleared.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Bundle of load-stream, fetch and decode signals between the instruction store
// and its surroundings (PC/loader side drives, the store responds).
interface instr_mem_loader_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int FIELD_W = 4,
    parameter int DEPTH   = 32
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic               InsMemRW;
    logic               wr_valid;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_ready;
    logic [CW-1:0]      loaded_cnt;
    logic               loading;
    logic               fetch_en;
    logic [ADDR_W-1:0]  IAddress;
    logic [DATA_W-1:0]  ins;
    logic               ins_valid;
    logic               addr_err;
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] rt;
    logic [FIELD_W-1:0] imm;

    modport slave (
        input  InsMemRW, wr_valid, wr_data, fetch_en, IAddress,
        output wr_ready, loaded_cnt, loading, ins, ins_valid, addr_err,
               op, rs, rt, imm
    );

    modport master (
        output InsMemRW, wr_valid, wr_data, fetch_en, IAddress,
        input  wr_ready, loaded_cnt, loading, ins, ins_valid, addr_err,
               op, rs, rt, imm
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction store: valid/ready load stream, registered fetch
// port and op/rs/rt/imm field split.
//
//  state | meaning
//  RUN   | fetches served from the store; InsMemRW=1 starts a fresh load
//  LOAD  | words streamed in at ptr until full; InsMemRW=0 returns to RUN
module instr_mem_loader #(
    parameter int              DATA_W  = 16,
    parameter int              DEPTH   = 32,
    parameter int              ADDR_W  = 16,
    parameter int              FIELD_W = 4,
    parameter logic [DATA_W-1:0] NOP   = '0
) (
    input  logic                 CLK,
    input  logic                 Reset,
    instr_mem_loader_if.slave    bus
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_W = (ADDR_W > 32) ? ADDR_W + 1 : 33;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DATA_W < 4 * FIELD_W) begin : g_param_chk
        $error("instr_mem_loader: DATA_W must be >= 4*FIELD_W");
    end

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [CW-1:0]      ptr;
    logic [DATA_W-1:0]  ins;
    logic               ins_valid;
    logic               addr_err;

    logic               wr_ready;
    logic               wr_accept;
    logic               fetch_go;
    logic               load_entry;
    logic               addr_in_range;
    logic [IW-1:0]      rd_idx;
    logic [IW-1:0]      wr_idx;
    logic [DATA_W-1:0]  rd_word;

    // Range check over the full address width so any set upper bit flags an error.
    assign addr_in_range = (CMP_W'(bus.IAddress) < CMP_W'(DEPTH));
    assign rd_idx        = bus.IAddress[IW-1:0];
    assign wr_idx        = ptr[IW-1:0];
    assign rd_word       = (addr_in_range && valid[rd_idx]) ? mem[rd_idx] : NOP;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ready   = 1'b0;
        wr_accept  = 1'b0;
        fetch_go   = 1'b0;
        load_entry = 1'b0;
        case (state)
            RUN: begin
                fetch_go   = bus.fetch_en;
                load_entry = bus.InsMemRW;
                if (bus.InsMemRW) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                wr_ready  = (ptr < DEPTH_C);
                wr_accept = wr_ready && bus.wr_valid;
                if (!bus.InsMemRW) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Valid bits, not the array, carry "written" status so reset stays cheap.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ptr       <= '0;
            valid     <= '0;
            ins       <= NOP;
            ins_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            ins_valid <= fetch_go;
            addr_err  <= fetch_go && !addr_in_range;
            if (fetch_go) begin
                ins <= rd_word;
            end
            if (load_entry) begin
                ptr   <= '0;
                valid <= '0;
            end else if (wr_accept) begin
                ptr            <= ptr + 1'b1;
                valid[wr_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.loaded_cnt = ptr;
    assign bus.loading    = (state == LOAD);
    assign bus.ins        = ins;
    assign bus.ins_valid  = ins_valid;
    assign bus.addr_err   = addr_err;
    assign bus.op         = ins[FIELD_W-1:0];
    assign bus.rs         = ins[2*FIELD_W-1:FIELD_W];
    assign bus.rt         = ins[3*FIELD_W-1:2*FIELD_W];
    assign bus.imm        = ins[4*FIELD_W-1:3*FIELD_W];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the store.
module tb_instr_mem_loader;
    localparam int          DATA_W  = 16;
    localparam int          DEPTH   = 32;
    localparam int          ADDR_W  = 16;
    localparam int          FIELD_W = 4;
    localparam logic [15:0] NOP     = 16'h0000;

    logic clk;
    logic rst;

    instr_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIELD_W(FIELD_W), .DEPTH(DEPTH)) bus ();

    instr_mem_loader #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FIELD_W(FIELD_W), .NOP(NOP)
    ) u_dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the loaded program is simply the queue of accepted words, in order.
    logic [15:0] m_q[$];
    bit          m_loading;
    logic [15:0] m_ins;
    bit          m_ins_valid;
    bit          m_addr_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("loading",    32'(bus.loading),    32'(m_loading));
        chk("wr_ready",   32'(bus.wr_ready),   32'(m_loading && m_q.size() < DEPTH));
        chk("loaded_cnt", 32'(bus.loaded_cnt), 32'(m_q.size()));
        chk("ins_valid",  32'(bus.ins_valid),  32'(m_ins_valid));
        chk("addr_err",   32'(bus.addr_err),   32'(m_addr_err));
        chk("ins",        32'(bus.ins),        32'(m_ins));
        chk("op",         32'(bus.op),         32'(m_ins % 16));
        chk("rs",         32'(bus.rs),         32'((m_ins / 16) % 16));
        chk("rt",         32'(bus.rt),         32'((m_ins / 256) % 16));
        chk("imm",        32'(bus.imm),        32'(m_ins / 4096));
    endtask

    task automatic tick();
        int a;
        a = int'(bus.IAddress);
        if (m_loading) begin
            if (bus.wr_valid && m_q.size() < DEPTH) m_q.push_back(bus.wr_data);
            m_ins_valid = 0;
            m_addr_err  = 0;
            if (!bus.InsMemRW) m_loading = 0;
        end else begin
            m_ins_valid = bus.fetch_en;
            m_addr_err  = 0;
            if (bus.fetch_en) begin
                if (a >= DEPTH) begin
                    m_addr_err = 1;
                    m_ins      = NOP;
                end else begin
                    m_ins = (a < m_q.size()) ? m_q[a] : NOP;
                end
            end
            if (bus.InsMemRW) begin
                m_loading = 1;
                m_q.delete();
            end
        end
        if (rst) begin
            m_loading   = 0;
            m_q.delete();
            m_ins       = NOP;
            m_ins_valid = 0;
            m_addr_err  = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic fetch(input logic [15:0] addr);
        bus.fetch_en = 1'b1;
        bus.IAddress = addr;
        tick();
        bus.fetch_en = 1'b0;
    endtask

    initial begin
        logic [15:0] w31;
        logic [15:0] w6;

        rst          = 1'b1;
        bus.InsMemRW = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.fetch_en = 1'b0;
        bus.IAddress = '0;
        m_loading    = 0;
        m_ins        = NOP;
        m_ins_valid  = 0;
        m_addr_err   = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: fetch after reset reads NOP
        fetch(16'h0000);
        chk("t1_ins_valid", 32'(bus.ins_valid), 32'd1);
        chk("t1_ins",       32'(bus.ins),       32'(NOP));

        // 2: two-word load then fetch word 1
        bus.InsMemRW = 1'b1;
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h1234;
        tick();
        bus.wr_data  = 16'hA0F1;
        tick();
        bus.wr_valid = 1'b0;
        bus.InsMemRW = 1'b0;
        tick();
        chk("t2_loaded_cnt", 32'(bus.loaded_cnt), 32'd2);
        fetch(16'd1);
        chk("t2_ins", 32'(bus.ins), 32'h0000_A0F1);
        chk("t2_op",  32'(bus.op),  32'h1);
        chk("t2_rs",  32'(bus.rs),  32'hF);
        chk("t2_rt",  32'(bus.rt),  32'h0);
        chk("t2_imm", 32'(bus.imm), 32'hA);

        // 3: fill to DEPTH, 33rd word offered but refused
        bus.InsMemRW = 1'b1;
        tick();
        bus.wr_valid = 1'b1;
        w31 = '0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.wr_data = 16'($urandom);
            if (i == DEPTH - 1) w31 = bus.wr_data;
            tick();
        end
        chk("t3_wr_ready",   32'(bus.wr_ready),   32'd0);
        chk("t3_loaded_cnt", 32'(bus.loaded_cnt), 32'(DEPTH));
        bus.wr_valid = 1'b0;
        bus.InsMemRW = 1'b0;
        tick();
        fetch(16'(DEPTH - 1));
        chk("t3_ins_last", 32'(bus.ins), 32'(w31));

        // 4: out-of-range addresses
        fetch(16'h0020);
        chk("t4_err_20", 32'(bus.addr_err), 32'd1);
        fetch(16'h8000);
        chk("t4_err_8000", 32'(bus.addr_err), 32'd1);
        chk("t4_ins_8000", 32'(bus.ins),      32'(NOP));

        // 5: reset aborts a partial load
        bus.InsMemRW = 1'b1;
        tick();
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 16'($urandom);
            tick();
        end
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.InsMemRW = 1'b0;
        tick();
        rst = 1'b0;
        chk("t5_loading",    32'(bus.loading),    32'd0);
        chk("t5_loaded_cnt", 32'(bus.loaded_cnt), 32'd0);
        fetch(16'd2);
        chk("t5_ins", 32'(bus.ins), 32'(NOP));

        // 6: fetch coinciding with load entry returns the old word
        bus.InsMemRW = 1'b1;
        tick();
        w6           = 16'h5A3C;
        bus.wr_valid = 1'b1;
        bus.wr_data  = w6;
        tick();
        bus.wr_valid = 1'b0;
        bus.InsMemRW = 1'b0;
        tick();
        bus.InsMemRW = 1'b1;
        fetch(16'd0);
        chk("t6_old_word", 32'(bus.ins),     32'(w6));
        chk("t6_loading",  32'(bus.loading), 32'd1);
        bus.InsMemRW = 1'b0;
        tick();
        fetch(16'd0);
        chk("t6_cleared", 32'(bus.ins), 32'(NOP));

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 8) bus.InsMemRW = ~bus.InsMemRW;
            bus.wr_valid = ($urandom_range(0, 99) < 70);
            bus.wr_data  = 16'($urandom);
            bus.fetch_en = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 3) == 0) bus.IAddress = 16'($urandom);
            else                           bus.IAddress = 16'($urandom_range(0, 39));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
